// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback sequencer slice.
package wb_pkg;

   typedef enum logic [1:0] {
      ALU     = 2'b00,
      LOAD    = 2'b01,
      SIGNEXT = 2'b10,
      LINK    = 2'b11
   } wb_class_t;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_MEM = 2'b01,
      WRITE    = 2'b10
   } wb_state_t;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_sequencer_if.sv
// Request, memory-handshake and register-file writeback signals of the sequencer.
interface wb_sequencer_if;

   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_class;
   logic       req_islwlr;
   logic [4:0] req_dest;
   logic       mem_data_valid;
   logic [1:0] select;
   logic       islwlr;
   logic       reg_write_en;
   logic [4:0] reg_write_addr;
   logic       stall;
   logic       mem_err;

   modport master (
      output req_valid, req_class, req_islwlr, req_dest, mem_data_valid,
      input  req_ready, select, islwlr, reg_write_en, reg_write_addr, stall, mem_err
   );

   modport slave (
      input  req_valid, req_class, req_islwlr, req_dest, mem_data_valid,
      output req_ready, select, islwlr, reg_write_en, reg_write_addr, stall, mem_err
   );

endinterface

// File: rtl/wb_timeout_counter.sv
// Saturating wait counter; expired is high once MEM_TIMEOUT cycles have been counted.
module wb_timeout_counter
   import wb_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   logic [CW-1:0] count;

   assign expired = (count == CW'(MEM_TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: accepts ALU/LOAD/SIGNEXT/LINK requests and issues one
// register-file write each, waiting for memory data (with timeout) on loads.
module wb_sequencer
   import wb_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input logic           clk,
   input logic           reset,
   wb_sequencer_if.slave bus
);

   wb_state_t  state;
   wb_state_t  state_nxt;
   wb_class_t  req_cls;
   wb_class_t  wb_cls;
   logic       wb_islwlr;
   logic [4:0] wb_dest;
   logic       ready;
   logic       stall_o;
   logic       wen;
   logic       accept;
   logic       load_accept;
   logic       in_wait;
   logic       tmo_expired;
   logic       mem_err_q;

   assign req_cls     = wb_class_t'(bus.req_class);
   assign accept      = bus.req_valid && ready;
   assign load_accept = accept && (req_cls == LOAD);
   assign in_wait     = (state == WAIT_MEM);

   wb_timeout_counter #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (load_accept),
      .enable  (in_wait),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // IDLE and WRITE share acceptance so back-to-back requests write every cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, WRITE: begin
            if (accept) begin
               state_nxt = (req_cls == LOAD) ? WAIT_MEM : WRITE;
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT_MEM: begin
            if (bus.mem_data_valid) begin
               state_nxt = WRITE;
            end else if (tmo_expired) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready   = 1'b1;
      stall_o = 1'b0;
      wen     = 1'b0;
      unique case (state)
         IDLE: ;
         WAIT_MEM: begin
            ready   = 1'b0;
            stall_o = 1'b1;
         end
         WRITE:    wen = (wb_dest != '0);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_cls    <= ALU;
         wb_islwlr <= 1'b0;
         wb_dest   <= '0;
      end else if (accept) begin
         wb_cls    <= req_cls;
         wb_islwlr <= bus.req_islwlr && (req_cls == LOAD);
         wb_dest   <= bus.req_dest;
      end
   end

   // Data arriving in the expiry cycle wins, so the error only latches without it.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_err_q <= 1'b0;
      end else if (in_wait && tmo_expired && !bus.mem_data_valid) begin
         mem_err_q <= 1'b1;
      end
   end

   assign bus.req_ready      = ready;
   assign bus.stall          = stall_o;
   assign bus.reg_write_en   = wen;
   assign bus.select         = wb_cls;
   assign bus.islwlr         = wb_islwlr;
   assign bus.reg_write_addr = wb_dest;
   assign bus.mem_err        = mem_err_q;

endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max cycles a load waits for memory data before abort.
REQ-002 SHALL have clk input 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have reset input 1: synchronous, active-high reset.
REQ-004 SHALL have req_valid input 1: a writeback request is presented.
REQ-005 SHALL have req_ready output 1: a request is accepted this cycle when req_valid and req_ready are both high.
REQ-006 SHALL have req_class input 2: 00 ALU, 01 LOAD, 10 SIGNEXT, 11 LINK; the encoding equals the writeback mux select.
REQ-007 SHALL have req_islwlr input 1: the load is LWL/LWR; meaningful only for LOAD.
REQ-008 SHALL have req_dest input 5: the destination register number.
REQ-009 SHALL have mem_data_valid input 1: load data is present on the data bus this cycle.
REQ-010 SHALL have select output 2: the writeback mux select.
REQ-011 SHALL have islwlr output 1: the writeback mux LWL/LWR qualifier.
REQ-012 SHALL have reg_write_en output 1: the register file write strobe.
REQ-013 SHALL have reg_write_addr output 5: the register file write address.
REQ-014 SHALL have stall output 1: high while a load waits for data.
REQ-015 SHALL have mem_err output 1: sticky flag for a load timeout.

Function
REQ-016 SHALL implement a state machine with states IDLE, WAIT_MEM and WRITE.
REQ-017 SHALL drive req_ready high in IDLE and WRITE, and low in WAIT_MEM.
REQ-018 SHALL, on accepting an ALU, SIGNEXT or LINK request, go to WRITE next cycle: latency exactly 1.
REQ-019 SHALL, on accepting a LOAD, go to WAIT_MEM; mem_data_valid in the accept cycle is ignored.
REQ-020 SHALL, in WAIT_MEM with mem_data_valid high, go to WRITE next cycle.
REQ-021 SHALL, in WRITE, drive reg_write_en high for that one cycle only, with select, islwlr and reg_write_addr taken from registered copies of the request.
REQ-022 SHALL, in WRITE with a new request accepted, go directly to WRITE or WAIT_MEM per the new request's class, giving one write per cycle for back-to-back ALU requests; otherwise WRITE goes to IDLE.
REQ-023 SHALL hold reg_write_en low in WRITE when the registered dest is 0, while still completing the state sequence.
REQ-024 SHALL force islwlr to 0 for every class other than LOAD.
REQ-025 SHALL drive stall high exactly while the state is WAIT_MEM.
REQ-026 SHALL count cycles spent in WAIT_MEM with a counter of width clog2(MEM_TIMEOUT+1), cleared on entry to WAIT_MEM.
REQ-027 SHALL, if the counter reaches MEM_TIMEOUT with mem_data_valid low, set mem_err, issue no write and go to IDLE next cycle.
REQ-028 SHALL give mem_data_valid priority over a timeout that occurs in the same cycle: the write proceeds and mem_err is not set.
REQ-029 SHALL, while not in WRITE, hold select, islwlr and reg_write_addr at their last registered values, with reg_write_en low.

Reset
REQ-030 SHALL, on reset, force the state to IDLE and set req_ready=1, reg_write_en=0, select=00, islwlr=0, reg_write_addr=0, stall=0, mem_err=0 and the counter to 0.
REQ-031 SHALL, on reset in WAIT_MEM or WRITE, abandon the in-flight request with no write issued in the following cycle.
REQ-032 SHALL clear mem_err only by reset.

Structure
REQ-033 SHALL place in shared package wb_pkg: the wb_class_t enum (ALU, LOAD, SIGNEXT, LINK with the encodings above), the wb_state_t enum and the default MEM_TIMEOUT constant.
REQ-034 SHALL implement the timeout counter as one sub-module, wb_timeout_counter, with clear, enable and expired ports.

Verification
REQ-035 SHALL verify ALU request with dest=5 accepted at cycle 0 -> cycle 1 shows reg_write_en=1, select=00, addr=5; cycle 2 shows reg_write_en=0.
REQ-036 SHALL verify four back-to-back LINK requests with dest=31 -> reg_write_en high for 4 consecutive cycles with select=11 and req_ready never low.
REQ-037 SHALL verify LOAD with islwlr=1, dest=8 and mem_data_valid high 3 cycles after accept -> stall high for 3 cycles, then one write with select=01, islwlr=1, addr=8.
REQ-038 SHALL verify LOAD with MEM_TIMEOUT=4 and mem_data_valid never high -> mem_err=1, no write, IDLE, req_ready=1; mem_err stays set until reset.
REQ-039 SHALL verify SIGNEXT request with dest=0 -> state passes through WRITE with reg_write_en never high.
REQ-040 SHALL verify reset asserted during WAIT_MEM, then mem_data_valid high in the next cycle -> no write, all outputs at reset values.
